// File: rtl/axi_lite_regfile_slave_if.sv
// AXI4-Lite bus bundle between the interconnect and the DMA register-file front-end.
interface axi_lite_regfile_slave_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 10
);
  logic [AXI_ADDR_WIDTH-1:0] s_awaddr;
  logic                      s_awvalid;
  logic                      s_awready;
  logic [DATA_WIDTH-1:0]     s_wdata;
  logic [DATA_WIDTH/8-1:0]   s_wstrb;
  logic                      s_wvalid;
  logic                      s_wready;
  logic [1:0]                s_bresp;
  logic                      s_bvalid;
  logic                      s_bready;
  logic [AXI_ADDR_WIDTH-1:0] s_araddr;
  logic                      s_arvalid;
  logic                      s_arready;
  logic [DATA_WIDTH-1:0]     s_rdata;
  logic [1:0]                s_rresp;
  logic                      s_rvalid;
  logic                      s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave that turns host reads/writes into single-cycle strobes on the
// DMA register file's slave port; read and write paths are independent FSMs.
module axi_lite_regfile_slave #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int AXI_ADDR_WIDTH = ADDR_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  axi_lite_regfile_slave_if.slave bus,
  output logic                  rf_write_enable,
  output logic [DATA_WIDTH-1:0] rf_datain,
  output logic [ADDR_WIDTH-1:0] rf_writeAddr,
  input  logic                  rf_writeReady,
  output logic                  rf_read_enable,
  output logic [ADDR_WIDTH-1:0] rf_readAddr,
  input  logic [DATA_WIDTH-1:0] rf_dataout,
  input  logic                  rf_readReady
);

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_CAPT, R_RESP} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                      aw_captured, w_captured;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]     wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;
  logic [1:0]                rresp_q;
  logic                      aw_ready, w_ready, ar_ready;
  logic                      aw_hs, w_hs, b_hs, ar_hs;
  logic                      w_err, r_err;

  // Readies are gated by reset so nothing is offered while the block is held.
  assign aw_ready = (w_state == W_IDLE) && !aw_captured && !reset;
  assign w_ready  = (w_state == W_IDLE) && !w_captured && !reset;
  assign ar_ready = (r_state == R_IDLE) && !reset;

  assign aw_hs = bus.s_awvalid && aw_ready;
  assign w_hs  = bus.s_wvalid && w_ready;
  assign b_hs  = bus.s_bvalid && bus.s_bready;
  assign ar_hs = bus.s_arvalid && ar_ready;

  assign w_err = (awaddr_q[1:0] != 2'b00) || (wstrb_q != '1);
  assign r_err = (araddr_q[1:0] != 2'b00);

  assign bus.s_awready = aw_ready;
  assign bus.s_wready  = w_ready;
  assign bus.s_arready = ar_ready;
  assign bus.s_rdata   = rdata_q;
  assign bus.s_rresp   = rresp_q;

  assign rf_datain    = wdata_q;
  assign rf_writeAddr = awaddr_q[AXI_ADDR_WIDTH-1:2];
  assign rf_readAddr  = araddr_q[AXI_ADDR_WIDTH-1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state     <= W_IDLE;
      aw_captured <= 1'b0;
      w_captured  <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        aw_captured <= 1'b1;
        awaddr_q    <= bus.s_awaddr;
      end
      if (w_hs) begin
        w_captured <= 1'b1;
        wdata_q    <= bus.s_wdata;
        wstrb_q    <= bus.s_wstrb;
      end
      if (b_hs) begin
        aw_captured <= 1'b0;
        w_captured  <= 1'b0;
      end
    end
  end

  // Leaving IDLE on the edge that completes the AW/W pair keeps the strobe one cycle after it.
  always_comb begin
    w_next          = w_state;
    rf_write_enable = 1'b0;
    bus.s_bvalid    = 1'b0;
    bus.s_bresp     = 2'b00;
    case (w_state)
      W_IDLE: begin
        if ((aw_captured || aw_hs) && (w_captured || w_hs)) w_next = W_ISSUE;
      end
      W_ISSUE: begin
        if (rf_writeReady) begin
          rf_write_enable = !w_err;
          w_next          = W_RESP;
        end
      end
      W_RESP: begin
        bus.s_bvalid = 1'b1;
        bus.s_bresp  = w_err ? 2'b10 : 2'b00;
        if (bus.s_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= R_IDLE;
      araddr_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      r_state <= r_next;
      if (ar_hs) araddr_q <= bus.s_araddr;
      if (r_state == R_CAPT) begin
        rdata_q <= r_err ? '0 : rf_dataout;
        rresp_q <= r_err ? 2'b10 : 2'b00;
      end
    end
  end

  // R_CAPT exists because the register file returns data one cycle after the strobe.
  always_comb begin
    r_next         = r_state;
    rf_read_enable = 1'b0;
    bus.s_rvalid   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) r_next = R_ISSUE;
      end
      R_ISSUE: begin
        if (rf_readReady) begin
          rf_read_enable = !r_err;
          r_next         = R_CAPT;
        end
      end
      R_CAPT: r_next = R_RESP;
      R_RESP: begin
        bus.s_rvalid = 1'b1;
        if (bus.s_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Self-checking bench for axi_lite_regfile_slave: directed cases then randomized
// traffic against an abstract register-file reference model.
module tb_axi_lite_regfile_slave;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int AAW = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_lite_regfile_slave_if #(.DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AAW)) bif ();

  logic          rf_write_enable, rf_read_enable;
  logic          rf_writeReady, rf_readReady;
  logic [DW-1:0] rf_datain, rf_dataout;
  logic [AW-1:0] rf_writeAddr, rf_readAddr;

  axi_lite_regfile_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AXI_ADDR_WIDTH(AAW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif),
    .rf_write_enable(rf_write_enable),
    .rf_datain(rf_datain),
    .rf_writeAddr(rf_writeAddr),
    .rf_writeReady(rf_writeReady),
    .rf_read_enable(rf_read_enable),
    .rf_readAddr(rf_readAddr),
    .rf_dataout(rf_dataout),
    .rf_readReady(rf_readReady)
  );

  int errors = 0;
  int checks = 0;
  bit stallMode = 1'b0;
  bit wrReadyCmd = 1'b1;
  bit rdReadyCmd = 1'b1;
  logic [31:0] refMem [256];

  // Register file: read returns the pre-write contents when both hit the same word.
  initial begin
    logic [31:0] rfMem [256];
    for (int i = 0; i < 256; i++) rfMem[i] = {24'hC0FFEE, i[7:0]};
    rf_dataout <= '0;
    forever begin
      @(posedge clk);
      if (rf_read_enable) rf_dataout <= rfMem[rf_readAddr];
      if (rf_write_enable) rfMem[rf_writeAddr] = rf_datain;
    end
  end

  initial begin
    rf_writeReady = 1'b1;
    rf_readReady  = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stallMode) begin
        rf_writeReady = ($urandom_range(0, 3) != 0);
        rf_readReady  = ($urandom_range(0, 3) != 0);
      end else begin
        rf_writeReady = wrReadyCmd;
        rf_readReady  = rdReadyCmd;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference write: only aligned full-word writes land; anything else is SLVERR.
  function automatic logic [1:0] refWrite(input logic [9:0] addr, input logic [31:0] data,
                                          input logic [3:0] strb);
    if (addr[1:0] == 2'b00 && strb == 4'hF) begin
      refMem[addr[9:2]] = data;
      return 2'b00;
    end
    return 2'b10;
  endfunction

  task automatic axiWrite(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int wLead, input int bHold,
                          output logic [1:0] resp, output int weCnt, output int weDelta,
                          output int bvDelta, output int protoErr,
                          output logic [7:0] weAddr, output logic [31:0] weData);
    int t, awStart, wStart, hsEdge, bvAt;
    bit awDone, wDone, done, awHs, wHs;
    resp = 2'b11; weCnt = 0; weDelta = -1; bvDelta = -1; protoErr = 0;
    weAddr = '0; weData = '0; hsEdge = -1; bvAt = -1;
    awDone = 0; wDone = 0; done = 0; t = 0;
    awStart = (wLead > 0) ? wLead : 0;
    wStart  = (wLead < 0) ? -wLead : 0;
    bif.s_awaddr = addr;
    bif.s_wdata  = data;
    bif.s_wstrb  = strb;
    while (!done && t < 200) begin
      @(negedge clk);
      if (rf_write_enable) begin
        weCnt++;
        weDelta = t - hsEdge;
        weAddr  = rf_writeAddr;
        weData  = rf_datain;
      end
      if (bif.s_bvalid && bvAt < 0) begin
        bvAt    = t;
        bvDelta = t - hsEdge;
      end
      if (bvAt >= 0 && !bif.s_bvalid) protoErr++;
      if (wDone && !awDone && bif.s_wready) protoErr++;
      if (awDone && !wDone && bif.s_awready) protoErr++;
      bif.s_awvalid = !awDone && (t >= awStart);
      bif.s_wvalid  = !wDone && (t >= wStart);
      bif.s_bready  = (bvAt >= 0) && (t >= bvAt + bHold);
      awHs = bif.s_awvalid && bif.s_awready;
      wHs  = bif.s_wvalid && bif.s_wready;
      if (awHs) awDone = 1;
      if (wHs) wDone = 1;
      if ((awHs || wHs) && awDone && wDone) hsEdge = t;
      if (bif.s_bvalid && bif.s_bready) begin
        resp = bif.s_bresp;
        done = 1;
      end
      t++;
    end
    @(posedge clk);
    #1;
    bif.s_awvalid = 1'b0;
    bif.s_wvalid  = 1'b0;
    bif.s_bready  = 1'b0;
    checkOutput("wr_completed", done, 1'b1);
  endtask

  task automatic axiRead(input logic [9:0] addr, input int arDelay, input int rHold,
                         output logic [31:0] data, output logic [1:0] resp,
                         output int reCnt, output int reDelta, output int rvDelta,
                         output int protoErr, output logic [7:0] reAddr);
    int t, hsEdge, rvAt;
    bit arDone, done;
    data = 'x; resp = 2'b11; reCnt = 0; reDelta = -1; rvDelta = -1; protoErr = 0;
    reAddr = '0; hsEdge = -1; rvAt = -1; arDone = 0; done = 0; t = 0;
    bif.s_araddr = addr;
    while (!done && t < 200) begin
      @(negedge clk);
      if (rf_read_enable) begin
        reCnt++;
        reDelta = t - hsEdge;
        reAddr  = rf_readAddr;
      end
      if (bif.s_rvalid && rvAt < 0) begin
        rvAt    = t;
        rvDelta = t - hsEdge;
        data    = bif.s_rdata;
        resp    = bif.s_rresp;
      end
      if (rvAt >= 0 && (!bif.s_rvalid || bif.s_rdata !== data || bif.s_rresp !== resp)) protoErr++;
      if (arDone && rvAt < 0 && bif.s_arready) protoErr++;
      bif.s_arvalid = !arDone && (t >= arDelay);
      bif.s_rready  = (rvAt >= 0) && (t >= rvAt + rHold);
      if (bif.s_arvalid && bif.s_arready) begin
        arDone = 1;
        hsEdge = t;
      end
      if (bif.s_rvalid && bif.s_rready) done = 1;
      t++;
    end
    @(posedge clk);
    #1;
    bif.s_arvalid = 1'b0;
    bif.s_rready  = 1'b0;
    checkOutput("rd_completed", done, 1'b1);
  endtask

  // Full directed write: drive, then compare response, strobe and latency with the model.
  task automatic applyStimulus(input string tag, input logic [9:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int wLead, input bit timed);
    logic [1:0] resp, expResp;
    int weCnt, weDelta, bvDelta, proto;
    logic [7:0] weAddr;
    logic [31:0] weData;
    axiWrite(addr, data, strb, wLead, 1, resp, weCnt, weDelta, bvDelta, proto, weAddr, weData);
    expResp = refWrite(addr, data, strb);
    checkOutput({tag, "_bresp"}, resp, expResp);
    checkOutput({tag, "_we_count"}, weCnt, (expResp == 2'b00) ? 1 : 0);
    checkOutput({tag, "_protocol"}, proto, 0);
    if (expResp == 2'b00) begin
      checkOutput({tag, "_we_addr"}, weAddr, addr[9:2]);
      checkOutput({tag, "_we_data"}, weData, data);
    end
    if (timed) begin
      if (expResp == 2'b00) checkOutput({tag, "_we_latency"}, weDelta, 1);
      checkOutput({tag, "_bvalid_latency"}, bvDelta, 2);
    end
  endtask

  task automatic readCheck(input string tag, input logic [9:0] addr, input int rHold, input bit timed);
    logic [31:0] data, expData;
    logic [1:0] resp;
    int reCnt, reDelta, rvDelta, proto;
    logic [7:0] reAddr;
    bit ok;
    ok = (addr[1:0] == 2'b00);
    expData = ok ? refMem[addr[9:2]] : 32'h0;
    axiRead(addr, 0, rHold, data, resp, reCnt, reDelta, rvDelta, proto, reAddr);
    checkOutput({tag, "_rdata"}, data, expData);
    checkOutput({tag, "_rresp"}, resp, ok ? 2'b00 : 2'b10);
    checkOutput({tag, "_re_count"}, reCnt, ok ? 1 : 0);
    checkOutput({tag, "_protocol"}, proto, 0);
    if (ok) checkOutput({tag, "_re_addr"}, reAddr, addr[9:2]);
    if (timed) begin
      if (ok) checkOutput({tag, "_re_latency"}, reDelta, 1);
      checkOutput({tag, "_rvalid_latency"}, rvDelta, 3);
    end
  endtask

  initial begin
    logic [31:0] rdA, rdB, rstData;
    logic [1:0] rsA, rsB, wrResp;
    int n1, n2, n3, n4, p1, p2, strobes, valids;
    logic [7:0] a8;
    logic [31:0] d32;
    logic [9:0] rAddr;
    logic [3:0] rStrb;

    for (int i = 0; i < 256; i++) refMem[i] = {24'hC0FFEE, i[7:0]};
    bif.s_awvalid = 0; bif.s_wvalid = 0; bif.s_bready = 0;
    bif.s_arvalid = 0; bif.s_rready = 0;
    bif.s_awaddr = '0; bif.s_wdata = '0; bif.s_wstrb = '0; bif.s_araddr = '0;
    reset = 1'b1;
    #1;
    $display("[TB] checking reset values");
    checkOutput("rst_readies", {bif.s_awready, bif.s_wready, bif.s_arready}, 3'b000);
    checkOutput("rst_valids", {bif.s_bvalid, bif.s_rvalid}, 2'b00);
    checkOutput("rst_resps", {bif.s_bresp, bif.s_rresp}, 4'b0000);
    checkOutput("rst_rdata", bif.s_rdata, 32'h0);
    checkOutput("rst_strobes", {rf_write_enable, rf_read_enable}, 2'b00);
    checkOutput("rst_rf_bus", {rf_datain, rf_writeAddr, rf_readAddr}, 48'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed writes and reads");
    applyStimulus("wr_same_cycle", 10'h010, 32'hDEADBEEF, 4'hF, 0, 1'b1);
    applyStimulus("wr_w_first", 10'h008, 32'h00000005, 4'hF, 3, 1'b0);
    readCheck("rd_10_held", 10'h010, 5, 1'b1);
    readCheck("rd_08", 10'h008, 0, 1'b1);
    applyStimulus("wr_misaligned", 10'h011, 32'h11111111, 4'hF, 0, 1'b1);
    applyStimulus("wr_partial_strb", 10'h014, 32'h22222222, 4'b0011, -2, 1'b1);
    readCheck("rd_misaligned", 10'h013, 0, 1'b1);
    readCheck("rd_14_untouched", 10'h014, 1, 1'b0);

    $display("[TB] concurrent read/write ordering");
    applyStimulus("wr_pre_aaaa", 10'h020, 32'h0000AAAA, 4'hF, 0, 1'b0);
    fork
      axiWrite(10'h020, 32'h00001234, 4'hF, 0, 0, wrResp, n1, n2, n3, p1, a8, d32);
      axiRead(10'h020, 0, 0, rdA, rsA, n4, strobes, valids, p2, a8);
    join
    checkOutput("same_cycle_rdata_old", rdA, refMem[8]);
    checkOutput("same_cycle_we_latency", n2, 1);
    checkOutput("same_cycle_re_latency", strobes, 1);
    checkOutput("same_cycle_bresp", wrResp, refWrite(10'h020, 32'h00001234, 4'hF));
    applyStimulus("wr_pre_aaaa_2", 10'h020, 32'h0000AAAA, 4'hF, 0, 1'b0);
    fork
      axiWrite(10'h020, 32'h00001234, 4'hF, 0, 0, wrResp, n1, n2, n3, p1, a8, d32);
      axiRead(10'h020, 1, 0, rdB, rsB, n4, strobes, valids, p2, a8);
    join
    checkOutput("bresp_after_write", wrResp, refWrite(10'h020, 32'h00001234, 4'hF));
    checkOutput("next_cycle_rdata_new", rdB, refMem[8]);
    checkOutput("next_cycle_rresp", rsB, 2'b00);

    $display("[TB] reset in the middle of transactions");
    rstData = 32'h0BADF00D;
    rdReadyCmd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bif.s_awaddr = 10'h030; bif.s_wdata = rstData; bif.s_wstrb = 4'hF;
    bif.s_araddr = 10'h030;
    bif.s_awvalid = 1; bif.s_wvalid = 1; bif.s_arvalid = 1; bif.s_bready = 0;
    @(negedge clk);
    bif.s_awvalid = 0; bif.s_wvalid = 0; bif.s_arvalid = 0;
    repeat (2) @(negedge clk);
    checkOutput("mid_bvalid_waiting", bif.s_bvalid, 1'b1);
    checkOutput("mid_rvalid_stalled", bif.s_rvalid, 1'b0);
    wrResp = refWrite(10'h030, rstData, 4'hF);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_valids", {bif.s_bvalid, bif.s_rvalid}, 2'b00);
    checkOutput("rst_mid_readies", {bif.s_awready, bif.s_wready, bif.s_arready}, 3'b000);
    @(negedge clk);
    rdReadyCmd = 1'b1;
    reset = 1'b0;
    strobes = 0;
    valids = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      strobes += int'(rf_write_enable) + int'(rf_read_enable);
      valids  += int'(bif.s_bvalid) + int'(bif.s_rvalid);
    end
    checkOutput("post_rst_no_strobe", strobes, 0);
    checkOutput("post_rst_no_response", valids, 0);
    readCheck("post_rst_read", 10'h030, 0, 1'b1);
    applyStimulus("post_rst_write", 10'h034, 32'hFEEDFACE, 4'hF, 1, 1'b1);
    readCheck("post_rst_readback", 10'h034, 0, 1'b1);

    $display("[TB] randomized traffic with register-file stalls");
    stallMode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      rAddr = {2'b00, 4'($urandom_range(0, 15)), 2'b00, 2'b00};
      if ($urandom_range(0, 5) == 0) rAddr[1:0] = 2'($urandom_range(1, 3));
      rStrb = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      if ($urandom_range(0, 1) == 0)
        applyStimulus("rand_wr", rAddr, $urandom, rStrb, $urandom_range(0, 4) - 2, 1'b0);
      else
        readCheck("rand_rd", rAddr, $urandom_range(0, 2), 1'b0);
    end
    stallMode = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_lite_regfile_slave.md
Name: axi_lite_regfile_slave

Overview:
- AXI4-Lite slave front-end for the DMA control/status register file.
- Converts host AXI4-Lite write and read transactions into single-cycle accesses on the register file's slave port: one write port, and one read port with 1-cycle read latency.
- Sits between the system interconnect and the register file. The main DMA FSM reads descriptors through the register file's other ports and never touches this block.

Parameters:
- DATA_WIDTH, 32, data width of the AXI bus and register file; must be 32.
- ADDR_WIDTH, 8, register-file word-address width.
- AXI_ADDR_WIDTH, ADDR_WIDTH+2, byte address width on AXI.

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- s_awaddr  in  AXI_ADDR_WIDTH  write address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  DATA_WIDTH/8  write strobes
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  AXI_ADDR_WIDTH  read address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  DATA_WIDTH  read data
- s_rresp  out  2  read response
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- rf_write_enable  out  1  register-file write strobe
- rf_datain  out  DATA_WIDTH  register-file write data
- rf_writeAddr  out  ADDR_WIDTH  register-file write word address, = awaddr[AXI_ADDR_WIDTH-1:2]
- rf_writeReady  in  1  register file can accept a write
- rf_read_enable  out  1  register-file read strobe
- rf_readAddr  out  ADDR_WIDTH  register-file read word address
- rf_dataout  in  DATA_WIDTH  register-file read data, valid the cycle after rf_read_enable
- rf_readReady  in  1  register file can accept a read

Behaviour:
- Reset (asynchronous, active-high) forces both FSMs to IDLE and clears the captured AW/W flags.
- Output values during reset: s_awready=0, s_wready=0, s_arready=0, s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0, rf_write_enable=0, rf_read_enable=0, rf_datain=0, rf_writeAddr=0, rf_readAddr=0.
- Reset mid-transaction abandons the transaction: no rf strobe and no response is issued afterwards.

Write FSM: W_IDLE -> W_ISSUE -> W_RESP -> W_IDLE.
- W_IDLE:
  - s_awready = !aw_captured.
  - s_wready = !w_captured.
  - AW and W may arrive in either order or in the same cycle. Each is latched on its own handshake.
  - When both are captured, go to W_ISSUE on the next edge.
- W_ISSUE:
  - Wait while rf_writeReady=0.
  - When rf_writeReady=1: rf_write_enable=1 for exactly one cycle, unless the access is an error; then go to W_RESP.
  - Error = awaddr[1:0]!=0, or s_wstrb != all ones. An error suppresses the rf write.
- W_RESP:
  - s_bvalid=1; s_bresp=2'b00 OKAY or 2'b10 SLVERR.
  - Hold until s_bready. Handshake clears the captured flags and returns to W_IDLE.
- Latency: with both AW and W handshaken at edge N and rf_writeReady=1, rf_write_enable is high in cycle N+1 and s_bvalid rises in cycle N+2.
- Best-case throughput: one write per 3 cycles.

Read FSM: R_IDLE -> R_ISSUE -> R_CAPT -> R_RESP -> R_IDLE.
- R_IDLE: s_arready=1; latch the address on handshake.
- R_ISSUE:
  - Wait while rf_readReady=0.
  - Otherwise: rf_read_enable=1 for one cycle with rf_readAddr = araddr[AXI_ADDR_WIDTH-1:2]. Misaligned araddr suppresses the strobe.
- R_CAPT: s_rdata <= rf_dataout, or 0 on error; s_rresp = OKAY or SLVERR.
- R_RESP:
  - s_rvalid=1.
  - s_rdata and s_rresp are held stable until s_rready, then return to R_IDLE.
- Latency: AR handshake at edge N; rf_read_enable in cycle N+1; s_rvalid rises in cycle N+3.

Concurrency and ordering:
- Read and write FSMs are fully independent; both rf strobes may be high in the same cycle.
- A same-cycle read and write to the same address returns the OLD value, per register-file timing.
- A read issued in the cycle after the write strobe returns the new value.
- Outstanding depth is one per direction: no new AW/W/AR is accepted until the prior response handshakes.
- s_bvalid/s_rvalid, once raised, never drop before their ready.

Test Plan:
- Write 0xDEADBEEF to 0x10 with AW and W in the same cycle -> rf_write_enable one cycle later, rf_writeAddr=4, rf_datain=0xDEADBEEF; s_bvalid 2 cycles after the handshake with bresp=00.
- W arrives 3 cycles before AW (data 0x5, addr 0x8) -> s_wready=0 after W capture; single rf write to addr 2; bresp=00.
- Read addr 0x10 after the above write -> rf_read_enable with rf_readAddr=4; s_rvalid 3 cycles after the AR handshake with s_rdata=0xDEADBEEF and rresp=00. Hold s_rready=0 for 5 cycles -> s_rdata stays stable.
- Write to 0x11 and write with wstrb=4'b0011 -> no rf_write_enable, bresp=10. Read 0x13 -> no rf_read_enable, rdata=0, rresp=10.
- Simultaneous write 0x1234 and read at addr 0x20 (old value 0xAAAA) -> read returns 0xAAAA. A read issued in the cycle after the write strobe returns 0x1234.
- Assert reset while in W_RESP with bready=0 and in R_ISSUE with rf_readReady=0 -> bvalid=0 and rvalid=0 immediately; no rf strobe follows; a fresh transaction after reset completes normally.
